// File: rtl/alu_control_mdu.sv
// EX-stage ALU control decode plus an iterative multiply/divide unit with HI/LO.
// Raises stall for the WIDTH+1 cycles each mult/div occupies EX.
module alu_control_mdu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       func_code,
    input  logic             issue,
    input  logic             flush,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [3:0]       alu_ctl,
    output logic [1:0]       result_sel,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mcand, orig_a, hi_r, lo_r;
    logic               neg_res, neg_rem, div_zero;

    logic               md_op, is_signed, a_neg, b_neg, last;
    logic [WIDTH-1:0]   abs_a, abs_b, quot, rem;
    logic [WIDTH:0]     mul_sum, div_trial;
    logic [2*WIDTH-1:0] mul_nxt, div_nxt, mul_prod;

    // NOTE: every output written in an always_comb gets a default first, so no path infers a latch.
    always_comb begin
        alu_ctl = 4'd15;
        unique case (alu_op)
            2'd0: alu_ctl = 4'd2;
            2'd1: alu_ctl = 4'd6;
            2'd3: alu_ctl = 4'd1;
            default: begin
                case (func_code)
                    6'd32, 6'd33: alu_ctl = 4'd2;
                    6'd34, 6'd35: alu_ctl = 4'd6;
                    6'd36:        alu_ctl = 4'd0;
                    6'd37:        alu_ctl = 4'd1;
                    6'd38:        alu_ctl = 4'd3;
                    6'd39:        alu_ctl = 4'd12;
                    6'd42:        alu_ctl = 4'd7;
                    6'd43:        alu_ctl = 4'd14;
                    6'd0:         alu_ctl = 4'd8;
                    6'd2:         alu_ctl = 4'd9;
                    6'd3:         alu_ctl = 4'd10;
                    6'd16, 6'd18, 6'd24, 6'd25, 6'd26, 6'd27: alu_ctl = 4'd2;
                    default:      alu_ctl = 4'd15;
                endcase
            end
        endcase
    end

    assign result_sel = (alu_op == 2'd2 && func_code == 6'd16) ? 2'd1 :
                        (alu_op == 2'd2 && func_code == 6'd18) ? 2'd2 : 2'd0;

    // funct 24..27; bit 0 clear means signed, bit 1 set means divide
    assign md_op     = issue && alu_op == 2'd2 && func_code[5:2] == 4'b0110;
    assign is_signed = ~func_code[0];
    assign a_neg     = is_signed & src_a[WIDTH-1];
    assign b_neg     = is_signed & src_b[WIDTH-1];
    assign abs_a     = a_neg ? -src_a : src_a;
    assign abs_b     = b_neg ? -src_b : src_b;
    assign last      = (cnt == CNT_W'(WIDTH - 1));

    // Shift-add: acc holds {partial product, remaining multiplier bits}
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mcand : {WIDTH{1'b0}})};
    assign mul_nxt  = {mul_sum, acc[WIDTH-1:1]};
    assign mul_prod = neg_res ? -mul_nxt : mul_nxt;

    // Restoring divide: acc holds {remainder, dividend bits / quotient bits}
    assign div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mcand};
    assign div_nxt   = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                        : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    assign quot      = div_nxt[WIDTH-1:0];
    assign rem       = div_nxt[2*WIDTH-1:WIDTH];

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        case (state)
            IDLE: if (md_op && !flush) begin
                stall     = 1'b1;
                state_nxt = func_code[1] ? DIV : MUL;
            end
            MUL, DIV: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else begin
                    stall = 1'b1;
                    if (last) state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            orig_a   <= '0;
            hi_r     <= '0;
            lo_r     <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (md_op && !flush) begin
                    cnt      <= '0;
                    neg_res  <= a_neg ^ b_neg;
                    neg_rem  <= a_neg;
                    div_zero <= (src_b == '0);
                    orig_a   <= src_a;
                    if (func_code[1]) begin
                        acc   <= {{WIDTH{1'b0}}, abs_a};
                        mcand <= abs_b;
                    end else begin
                        acc   <= {{WIDTH{1'b0}}, abs_b};
                        mcand <= abs_a;
                    end
                end
                MUL: if (!flush) begin
                    acc <= mul_nxt;
                    cnt <= cnt + 1'b1;
                    if (last) {hi_r, lo_r} <= mul_prod;
                end
                DIV: if (!flush) begin
                    acc <= div_nxt;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        if (div_zero) begin
                            hi_r <= orig_a;
                            lo_r <= '1;
                        end else begin
                            hi_r <= neg_rem ? -rem : rem;
                            lo_r <= neg_res ? -quot : quot;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi = hi_r;
    assign lo = lo_r;
endmodule

// File: tb/tb_alu_control_mdu.sv
// Directed bench for alu_control_mdu: decode sweep, mult/div results and latency,
// flush and reset mid-operation, back-to-back operations.
module tb_alu_control_mdu;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   alu_op;
    logic [5:0]   func_code;
    logic         issue, flush;
    logic [W-1:0] src_a, src_b;
    logic [3:0]   alu_ctl;
    logic [1:0]   result_sel;
    logic         stall;
    logic [W-1:0] hi, lo;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    alu_control_mdu #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .alu_op(alu_op), .func_code(func_code),
        .issue(issue), .flush(flush), .src_a(src_a), .src_b(src_b),
        .alu_ctl(alu_ctl), .result_sel(result_sel), .stall(stall),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] exp_ctl(input int op, input int f);
        if (op == 0) return 4'd2;
        if (op == 1) return 4'd6;
        if (op == 3) return 4'd1;
        case (f)
            32, 33: return 4'd2;
            34, 35: return 4'd6;
            36:     return 4'd0;
            37:     return 4'd1;
            38:     return 4'd3;
            39:     return 4'd12;
            42:     return 4'd7;
            43:     return 4'd14;
            0:      return 4'd8;
            2:      return 4'd9;
            3:      return 4'd10;
            16, 18, 24, 25, 26, 27: return 4'd2;
            default: return 4'd15;
        endcase
    endfunction

    function automatic logic [1:0] exp_sel(input int op, input int f);
        if (op == 2 && f == 16) return 2'd1;
        if (op == 2 && f == 18) return 2'd2;
        return 2'd0;
    endfunction

    // Presents an MD op, counts stall cycles, and checks HI/LO in the DONE cycle.
    task automatic run_md(input string tag, input logic [5:0] f, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                          input logic [W-1:0] exp_lo);
        int n;
        alu_op = 2'd2; func_code = f; issue = 1'b1; flush = 1'b0;
        src_a = a; src_b = b;
        #1;
        n = 0;
        while (stall === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        check({tag, " stall cycles"}, 64'(n), 64'd33);
        check({tag, " done stall"}, {63'd0, stall}, 64'd0);
        check({tag, " hi"}, {32'd0, hi}, {32'd0, exp_hi});
        check({tag, " lo"}, {32'd0, lo}, {32'd0, exp_lo});
    endtask

    initial begin
        rst_n = 1'b0; alu_op = 2'd0; func_code = 6'd0; issue = 1'b0; flush = 1'b0;
        src_a = '0; src_b = '0;
        tick();
        tick();
        check("reset hi", {32'd0, hi}, 64'd0);
        check("reset lo", {32'd0, lo}, 64'd0);
        check("reset stall", {63'd0, stall}, 64'd0);
        rst_n = 1'b1;
        tick();

        for (int op = 0; op < 4; op++) begin
            for (int f = 0; f < 64; f++) begin
                alu_op = 2'(op); func_code = 6'(f);
                #1;
                check($sformatf("decode ctl op%0d f%0d", op, f), {60'd0, alu_ctl}, {60'd0, exp_ctl(op, f)});
                check($sformatf("decode sel op%0d f%0d", op, f), {62'd0, result_sel}, {62'd0, exp_sel(op, f)});
            end
        end
        check("no issue no stall", {63'd0, stall}, 64'd0);

        // Flush in IDLE: no op accepted
        alu_op = 2'd2; func_code = 6'd24; issue = 1'b1; flush = 1'b1;
        src_a = 32'd3; src_b = 32'd5;
        #1;
        check("idle flush stall", {63'd0, stall}, 64'd0);
        tick();
        check("idle flush stays idle", {63'd0, stall}, 64'd0);
        issue = 1'b0; flush = 1'b0;
        tick();

        run_md("mult -3*7", 6'd24, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        tick();
        func_code = 6'd16; src_a = '0; src_b = '0;
        #1;
        check("mfhi result_sel", {62'd0, result_sel}, 64'd1);
        check("mfhi no stall", {63'd0, stall}, 64'd0);
        tick();
        check("mfhi keeps hi", {32'd0, hi}, 64'hFFFF_FFFF);
        issue = 1'b0;
        tick();

        run_md("multu", 6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        tick();
        run_md("div -7/2", 6'd26, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        tick();
        run_md("div min/-1", 6'd26, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        tick();

        // Flush during the 10th multiply iteration
        alu_op = 2'd2; func_code = 6'd24; issue = 1'b1; src_a = 32'd3; src_b = 32'd5;
        #1;
        repeat (10) tick();
        check("mid mult stall", {63'd0, stall}, 64'd1);
        flush = 1'b1;
        #1;
        check("flush drops stall", {63'd0, stall}, 64'd0);
        tick();
        flush = 1'b0; issue = 1'b0;
        #1;
        check("after flush stall", {63'd0, stall}, 64'd0);
        check("flush keeps hi", {32'd0, hi}, 64'd0);
        check("flush keeps lo", {32'd0, lo}, 64'h8000_0000);

        // Back-to-back: div presented the cycle after the mult's DONE
        run_md("mult 3*5", 6'd24, 32'd3, 32'd5, 32'd0, 32'd15);
        tick();
        run_md("div 100/7", 6'd26, 32'd100, 32'd7, 32'd2, 32'd14);
        tick();
        run_md("div -7/0", 6'd26, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        tick();

        // Reset during the 20th divide iteration
        alu_op = 2'd2; func_code = 6'd26; issue = 1'b1; src_a = 32'd9; src_b = 32'd2;
        #1;
        repeat (20) tick();
        check("mid div stall", {63'd0, stall}, 64'd1);
        rst_n = 1'b0; issue = 1'b0;
        tick();
        check("mid reset hi", {32'd0, hi}, 64'd0);
        check("mid reset lo", {32'd0, lo}, 64'd0);
        check("mid reset stall", {63'd0, stall}, 64'd0);
        rst_n = 1'b1;
        func_code = 6'd18; issue = 1'b1;
        #1;
        check("mflo result_sel", {62'd0, result_sel}, 64'd2);
        tick();

        run_md("divu 5/0", 6'd27, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
        tick();
        func_code = 6'd18;
        #1;
        check("mflo after divu", {62'd0, result_sel}, 64'd2);
        tick();
        check("mflo keeps lo", {32'd0, lo}, 64'hFFFF_FFFF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/alu_control_mdu.md
Name: alu_control_mdu

Overview:
- Next-generation EX-stage ALU control for the pipelined MIPS core.
- Decodes ALUOp/funct into the 4-bit ALU control code, extended with shifts, xor and sltu.
- Adds an iterative multiply/divide unit (MDU) with HI/LO registers.
- Raises a pipeline stall while a mult/div is in flight; selects the ALU, HI or LO result for mfhi/mflo.

Parameters:
- WIDTH, 32, operand and HI/LO width; must be ≥ 4 and even.
- CNT_W, 6, iteration-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- alu_op  input  2  main-control ALUOp: 0 add, 1 sub, 2 R-type, 3 or (ori).
- func_code  input  6  instruction funct field.
- issue  input  1  valid instruction present in EX this cycle.
- flush  input  1  squash the EX instruction and abort any MDU operation.
- src_a  input  WIDTH  rs operand.
- src_b  input  WIDTH  rt operand.
- alu_ctl  output  4  ALU control code (combinational).
- result_sel  output  2  0 ALU, 1 HI, 2 LO (combinational).
- stall  output  1  hold IF/ID/EX; EX instruction stays presented.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- alu_ctl decode:
  - alu_op 0 → 2; alu_op 1 → 6; alu_op 3 → 1.
  - alu_op 2, by funct: 32/33 → 2; 34/35 → 6; 36 → 0; 37 → 1; 38 → 3; 39 → 12; 42 → 7; 43 → 14; 0 (sll) → 8; 2 (srl) → 9; 3 (sra) → 10; 16, 18, 24–27 → 2; any other funct → 15.
- result_sel: 1 when alu_op=2 and funct=16; 2 when alu_op=2 and funct=18; else 0.
- MD op = issue & alu_op=2 & funct ∈ {24 mult, 25 multu, 26 div, 27 divu}.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE:
  - MD op & !flush → stall=1 combinationally.
  - Same edge: latch operand magnitudes (absolute values for signed ops), sign flags and op type; clear counter.
  - Go to MUL (24/25) or DIV (26/27).
- MUL:
  - Radix-2 shift-add, one bit per cycle, 2·WIDTH-bit accumulator; stall=1.
  - After WIDTH iterations: write HI:LO with the sign-corrected product; go to DONE.
- DIV:
  - Restoring division, one quotient bit per cycle; stall=1.
  - After WIDTH iterations: LO = quotient, HI = remainder, sign-corrected; go to DONE.
  - Signed division: quotient negative iff operand signs differ; remainder takes the dividend's sign.
  - Divide by zero (src_b = 0, signed or unsigned): full latency, then HI = src_a, LO = all ones.
  - Signed −2^(WIDTH−1) / −1: LO = −2^(WIDTH−1), HI = 0.
- DONE:
  - stall=0 so the pipeline advances; no new op accepted this cycle, even with an MD op still presented.
  - Next state IDLE.
- Latency: stall high for exactly WIDTH+1 consecutive cycles per MD op (accept cycle + WIDTH iterations).
  - HI/LO hold the new values in the DONE cycle.
  - An mfhi/mflo in EX on the next cycle reads the new values.
- flush:
  - In IDLE: no op accepted.
  - In MUL/DIV: go to IDLE next edge; HI/LO unchanged; stall drops combinationally that cycle.
  - In DONE: no effect; HI/LO already written.
- Reset (rst_n=0 at a rising edge, any state including mid-op): state IDLE, counter 0, hi=0, lo=0, stall=0.
- HI/LO change only at the MUL/DIV → DONE transition or on reset; mfhi/mflo never modify them.

Test Plan:
- Decode sweep: all 4 alu_op values × all 64 funct codes → alu_ctl and result_sel exactly per table; unlisted functs → 15.
- mult src_a=0xFFFFFFFD (−3), src_b=7:
  - stall high 33 cycles.
  - DONE cycle: hi=0xFFFFFFFF, lo=0xFFFFFFEB.
  - Following mfhi gives result_sel=1.
- multu 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- div/divu:
  - div −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - div 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
  - divu 5/0 → hi=5, lo=0xFFFFFFFF after 33 stall cycles.
- Abort/reset mid-op:
  - flush at iteration 10 of a mult → stall drops that cycle; hi/lo keep prior values; next MD op runs normally.
  - rst_n low at iteration 20 of a div → after the edge hi=lo=0, stall=0, FSM IDLE.
- Back-to-back: mult followed directly by div (div presented the cycle after DONE) → div accepted with no dropped stall gap; DONE cycle never re-accepts the completing mult.
